// File: rtl/ca_seq_pkg.sv
// Shared types and constants for the rule-110 array sequencer (ca_sequencer).
package ca_seq_pkg;

  localparam int CELLS_PER_BLOCK = 8;
  localparam int GEN_W           = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_SCAN = 2'd3
  } state_e;

  // The array aliases the all-ones block address onto block 0, so the top block is unusable.
  function automatic int use_blocks(input int num_cells);
    return num_cells / CELLS_PER_BLOCK - 1;
  endfunction

endpackage

// File: rtl/ca_sequencer.sv
// Load/run/scan sequencer for the rule-110 cell array's byte-wide block port.
// Optional per-generation scanning is compiled in with `define CA_SEQ_SCAN_EACH_EN.
module ca_sequencer
  import ca_seq_pkg::*;
#(
  parameter int NUM_CELLS = 128,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              cfg_load_i,
  input  logic [GEN_W-1:0]  cfg_gens_i,
  input  logic              cfg_scan_each_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [7:0]        ld_data_i,
  output logic              sc_valid_o,
  input  logic              sc_ready_i,
  output logic [7:0]        sc_data_o,
  output logic [ADDR_W-1:0] sc_block_o,
  output logic [GEN_W-1:0]  sc_gen_o,
  output logic              sc_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        ca_data_in_o,
  output logic              ca_we_n_o,
  output logic              ca_halt_n_o,
  output logic [ADDR_W-1:0] ca_addr_o,
  input  logic [7:0]        ca_data_out_i,
  output logic [1:0]        state_o
);

  localparam int                USE_BLOCKS = use_blocks(NUM_CELLS);
  localparam logic [ADDR_W-1:0] LAST_BLK   = ADDR_W'(USE_BLOCKS - 1);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_LOAD = S_LOAD;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_SCAN = S_SCAN;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] blk_q, blk_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [GEN_W-1:0]  gens_q, gens_d;
  logic              done_q, done_d;
  logic [GEN_W-1:0]  gen_nxt;
  logic              blk_last;
  logic              final_scan;
  logic              scan_each;

`ifdef CA_SEQ_SCAN_EACH_EN
  logic scan_each_q, scan_each_d;
  assign scan_each = scan_each_q;
`else
  logic unused_scan_each;
  assign unused_scan_each = cfg_scan_each_i;
  assign scan_each        = 1'b0;
`endif

  assign gen_nxt    = gen_q + GEN_W'(1);
  assign blk_last   = (blk_q == LAST_BLK);
  // Without per-step scanning the only scan is the final one.
  assign final_scan = !scan_each || (gen_q == gens_q);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // the sender holds data stable while valid is high and ready is low.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    gen_d        = gen_q;
    gens_d       = gens_q;
    done_d       = 1'b0;
`ifdef CA_SEQ_SCAN_EACH_EN
    scan_each_d  = scan_each_q;
`endif
    ld_ready_o   = 1'b0;
    sc_valid_o   = 1'b0;
    sc_data_o    = 8'h00;
    sc_block_o   = '0;
    sc_gen_o     = '0;
    sc_last_o    = 1'b0;
    ca_data_in_o = 8'h00;
    ca_we_n_o    = 1'b1;
    ca_halt_n_o  = 1'b0;
    ca_addr_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          gens_d = cfg_gens_i;
          gen_d  = '0;
          blk_d  = '0;
`ifdef CA_SEQ_SCAN_EACH_EN
          scan_each_d = cfg_scan_each_i;
`endif
          if (cfg_load_i)              state_d = ST_LOAD;
          else if (cfg_gens_i == '0)   state_d = ST_SCAN;
          else                         state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        ld_ready_o   = 1'b1;
        ca_we_n_o    = !ld_valid_i;
        ca_addr_o    = blk_q;
        ca_data_in_o = ld_data_i;
        if (ld_valid_i) begin
          if (blk_last) begin
            blk_d   = '0;
            state_d = (gens_q == '0) ? ST_SCAN : ST_RUN;
          end else begin
            blk_d = blk_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        ca_halt_n_o = 1'b1;
        gen_d       = gen_nxt;
        if (scan_each || (gen_nxt == gens_q)) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // The array is halted, so its read data is stable while the host stalls.
        sc_valid_o = 1'b1;
        sc_data_o  = ca_data_out_i;
        sc_block_o = blk_q;
        sc_gen_o   = gen_q;
        sc_last_o  = blk_last && final_scan;
        ca_addr_o  = blk_q;
        if (sc_ready_i) begin
          if (blk_last) begin
            blk_d = '0;
            if (final_scan) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            blk_d = blk_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      gen_q   <= '0;
      gens_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      gen_q   <= gen_d;
      gens_q  <= gens_d;
      done_q  <= done_d;
    end
  end

`ifdef CA_SEQ_SCAN_EACH_EN
  always_ff @(posedge clk) begin
    if (reset) scan_each_q <= 1'b0;
    else       scan_each_q <= scan_each_d;
  end
`endif

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ca_sequencer.sv
// Bench for ca_sequencer: emulates the rule-110 array and checks every scan beat against
// a whole-array generation model.
`timescale 1ns/1ps
module tb_ca_sequencer;
  import ca_seq_pkg::*;

  localparam int         NC   = 128;
  localparam int         AW   = 6;
  localparam int         NB   = 15;
  localparam int         EW   = 8 + AW + GEN_W + 1;
  localparam logic [7:0] RULE = 8'd110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  logic              start = 1'b0, cfg_load = 1'b0, cfg_scan_each = 1'b0;
  logic [GEN_W-1:0]  cfg_gens = '0;
  logic              ld_valid = 1'b0, ld_ready;
  logic [7:0]        ld_data = 8'h00;
  logic              sc_valid, sc_ready = 1'b1, sc_last;
  logic [7:0]        sc_data;
  logic [AW-1:0]     sc_block;
  logic [GEN_W-1:0]  sc_gen;
  logic              busy, done;
  logic [7:0]        ca_data_in, ca_data_out;
  logic              ca_we_n, ca_halt_n;
  logic [AW-1:0]     ca_addr;
  logic [1:0]        state_dbg;

  ca_sequencer #(.NUM_CELLS(NC), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start), .cfg_load_i(cfg_load),
    .cfg_gens_i(cfg_gens), .cfg_scan_each_i(cfg_scan_each),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_data_i(ld_data),
    .sc_valid_o(sc_valid), .sc_ready_i(sc_ready), .sc_data_o(sc_data),
    .sc_block_o(sc_block), .sc_gen_o(sc_gen), .sc_last_o(sc_last),
    .busy_o(busy), .done_o(done), .ca_data_in_o(ca_data_in),
    .ca_we_n_o(ca_we_n), .ca_halt_n_o(ca_halt_n), .ca_addr_o(ca_addr),
    .ca_data_out_i(ca_data_out), .state_o(state_dbg)
  );

  // Rule 110 over the whole array, zero outside both ends; left = cell i-1, right = cell i+1.
  function automatic logic [NC-1:0] rule110(input logic [NC-1:0] s);
    logic [NC-1:0] n;
    logic l, c, r;
    for (int i = 0; i < NC; i++) begin
      l    = (i > 0)      ? s[i-1] : 1'b0;
      c    = s[i];
      r    = (i < NC - 1) ? s[i+1] : 1'b0;
      n[i] = RULE[{l, c, r}];
    end
    return n;
  endfunction

  // ---------------- array emulation ----------------
  logic [NC-1:0] arr = '0;
  logic [NC-1:0] arr_nxt;
  assign arr_nxt     = rule110(arr);
  assign ca_data_out = arr_nxt[{ca_addr[3:0], 3'b000} +: 8];
  always @(posedge clk) begin
    if (!ca_we_n)      arr[{ca_addr[3:0], 3'b000} +: 8] <= ca_data_in;
    else if (ca_halt_n) arr <= arr_nxt;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0, n_err = 0;
  int            halt_cnt = 0, cyc = 0;
  logic          chk_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, fin_hs = 1'b0;
  logic [7:0]    seen_blk7 = 8'h00;
  logic          rnd_ready = 1'b0;
  logic [NC-1:0] mdl = '0;
  logic [7:0]    pat[NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    fin_hs = 1'b0;
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (ca_halt_n) halt_cnt++;
      if (!exp_busy)
        chk("idle_outs",
            {ld_ready, sc_valid, ca_we_n, ca_halt_n, ca_addr, ca_data_in, sc_last, sc_gen},
            {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, {GEN_W{1'b0}}});
      if (sc_valid) begin
        if (exp_q.size() == 0) chk("spurious_beat", sc_valid, 1'b0);
        else begin
          chk("scan_beat", {sc_data, sc_block, sc_gen, sc_last}, exp_q[0]);
          if (sc_ready) begin
            if (sc_block == AW'(7)) seen_blk7 = sc_data;
            fin_hs = exp_q[0][0];
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      exp_done <= fin_hs;
      if (fin_hs)                  exp_busy <= 1'b0;
      else if (!exp_busy && start) exp_busy <= 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    sc_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push_scan(input int g, input logic fin);
    logic [NC-1:0] f;
    f = rule110(mdl);
    for (int b = 0; b < NB; b++)
      exp_q.push_back({f[b*8 +: 8], AW'(b), GEN_W'(g), fin && (b == NB - 1)});
  endtask

  task automatic send_byte(input int b, input logic [7:0] v, input logic gap);
    int   t;
    logic rdy;
    if (gap && $urandom_range(0, 2) == 0) begin ld_valid = 1'b0; tick(); end
    ld_valid = 1'b1;
    ld_data  = v;
    t = 0;
    do begin
      @(negedge clk); rdy = ld_ready;
      @(posedge clk); #1; t++;
    end while (!rdy && t < 50);
    chk("ld_accept", rdy, 1'b1);
    if (rdy) mdl[b*8 +: 8] = v;
    ld_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic load, input int g, input logic se, input logic gap,
                         input logic hold_start, input int exp_len,
                         input logic chk_b7, input logic [7:0] exp_b7);
    int   c0, t;
    logic se_eff;
`ifdef CA_SEQ_SCAN_EACH_EN
    se_eff = se;
`else
    se_eff = 1'b0;
`endif
    start = 1'b1; cfg_load = load; cfg_gens = GEN_W'(g); cfg_scan_each = se;
    halt_cnt = 0;
    tick();
    c0    = cyc;
    start = hold_start;
    if (load) begin
      for (int b = 0; b < NB; b++) send_byte(b, pat[b], gap);
      start = 1'b0;
    end
    if (se_eff && g > 0) begin
      for (int i = 1; i <= g; i++) begin mdl = rule110(mdl); push_scan(i, i == g); end
    end else begin
      for (int i = 0; i < g; i++) mdl = rule110(mdl);
      push_scan(g, 1'b1);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 3000);
    chk("done_seen", done, 1'b1);
    if (exp_len > 0) chk("cmd_len", cyc - c0 + 1, exp_len);
    chk("halt_cycles", halt_cnt, g);
    chk("scan_drained", exp_q.size(), 0);
    if (chk_b7) chk("blk7_data", seen_blk7, exp_b7);
    exp_q.delete();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NC-1:0] p;
    logic [7:0]    v;

    // Model pins: single cell grows leftward 1 -> 11 -> 111 -> 1101 -> 11111.
    p = '0; p[60] = 1'b1;
    p = rule110(p);
    v = p[63:56]; chk("pin_gen1_blk7", v, 8'h18);
    p = rule110(rule110(rule110(p)));
    v = p[63:56]; chk("pin_gen4_blk7", v, 8'h1F);
    v = p[55:48]; chk("pin_gen4_blk6", v, 8'h00);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_halt_n", ca_halt_n, 1'b0);
    chk("rst_we_n", ca_we_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk_en = 1'b1;
    tick();

    // Single seed cell in block 7.
    for (int b = 0; b < NB; b++) pat[b] = 8'h00;
    pat[7] = 8'h10;
    run_cmd(1'b1, 0, 1'b0, 1'b0, 1'b0, 31, 1'b1, 8'h18);
    run_cmd(1'b1, 3, 1'b0, 1'b0, 1'b0, 34, 1'b1, 8'h1F);

    // Continue from the current array contents with backpressure.
    rnd_ready = 1'b1;
    run_cmd(1'b0, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h00);

    // Mixed pattern, gapped loading, start held while busy, per-step scan request.
    for (int b = 0; b < NB; b++) pat[b] = 8'(b * 37 + 11);
    rnd_ready = 1'b0;
`ifdef CA_SEQ_SCAN_EACH_EN
    run_cmd(1'b1, 2, 1'b1, 1'b0, 1'b1, 48, 1'b0, 8'h00);
`else
    run_cmd(1'b1, 2, 1'b1, 1'b0, 1'b1, 33, 1'b0, 8'h00);
`endif
    run_cmd(1'b0, 0, 1'b1, 1'b0, 1'b0, 16, 1'b0, 8'h00);
    rnd_ready = 1'b1;
    run_cmd(1'b1, 1, 1'b1, 1'b1, 1'b0, -1, 1'b0, 8'h00);

    // Reset during LOAD after five bytes; written blocks stay in the array.
    for (int b = 0; b < NB; b++) pat[b] = 8'hC3 ^ 8'(b);
    start = 1'b1; cfg_load = 1'b1; cfg_gens = GEN_W'(5); cfg_scan_each = 1'b0;
    tick();
    start = 1'b0;
    for (int b = 0; b < 5; b++) send_byte(b, pat[b], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ld_ready", ld_ready, 1'b0);
    tick();
    ld_valid = 1'b1; ld_data = 8'hFF;
    repeat (3) tick();
    ld_valid = 1'b0;
    rnd_ready = 1'b0;
    run_cmd(1'b0, 1, 1'b0, 1'b0, 1'b0, 17, 1'b0, 8'h00);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ca_sequencer.md
# ca_sequencer

Controller that sequences the rule-110 cell array through load, run and scan phases over the array's byte-wide block port. It streams an initial pattern in one 8-cell block per handshake, advances the automaton a programmed number of generations, then streams the array contents out block by block with valid/ready backpressure. It sits between a host-side streaming interface and the array's data, write-enable, halt and block-address pins, and owns all of those pins.

## Interface
- NUM_CELLS, 128, cells in the array; multiple of 8.
- CELLS_PER_BLOCK, 8, cells per block; fixed.
- ADDR_W, 6, width of the array block-address pins.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  command pulse; sampled only in IDLE.
- cfg_load  in  1  with start: 1 = load a pattern first, 0 = keep current array contents.
- cfg_gens  in  16  with start: generations to advance (0 allowed).
- cfg_scan_each  in  1  with start: scan after every generation (macro-gated).
- ld_valid / ld_ready  in / out  1 / 1  load-stream handshake.
- ld_data  in  8  block contents; bit 0 is the lowest cell of the block.
- sc_valid / sc_ready  out / in  1 / 1  scan-stream handshake.
- sc_data  out  8  block contents read from the array.
- sc_block  out  ADDR_W  block index of sc_data.
- sc_gen  out  16  generations advanced so far at this scan.
- sc_last  out  1  last beat of the final scan.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- ca_data_in  out  8  to the array data pins.
- ca_we_n  out  1  array write enable, active low.
- ca_halt_n  out  1  array run enable, active low halt.
- ca_addr  out  ADDR_W  array block address.
- ca_data_out  in  8  array block read data (combinational successor of stored state).

## Operation
- NUM_BLOCKS = NUM_CELLS/8. The array aliases the all-ones block address to block 0, so the controller addresses only blocks 0..NUM_BLOCKS-2 (USE_BLOCKS = 15 by default). The top block is never written or reported.
- Latched on start: cfg_load, cfg_gens and cfg_scan_each are captured into internal registers.
- States and transitions:
  - IDLE -> LOAD if cfg_load, else -> RUN.
  - LOAD -> RUN after USE_BLOCKS accepted bytes.
  - RUN -> SCAN when the generation counter reaches cfg_gens. With scan_each, RUN -> SCAN after every single step.
  - SCAN -> RUN if scan_each and generations remain, else -> IDLE.
- LOAD:
  - ld_ready = 1.
  - ca_we_n = !ld_valid, ca_halt_n = 0, ca_addr = block counter, ca_data_in = ld_data.
  - Counter increments on each handshake.
- RUN:
  - ca_we_n = 1, ca_halt_n = 1 for exactly one cycle per generation.
  - gen counter increments each cycle.
  - cfg_gens = 0 with scan_each clear: RUN lasts 0 cycles and passes straight to SCAN.
- SCAN:
  - ca_halt_n = 0, ca_we_n = 1.
  - sc_valid = 1, sc_data = ca_data_out, sc_block = ca_addr = block counter.
  - Counter advances on sc_valid && sc_ready.
  - Array state is frozen, so sc_data stays stable under backpressure.
  - The reported frame is the successor of the stored state: generation gens+1 relative to the loaded pattern.
- sc_last = 1 on block USE_BLOCKS-1 of the final scan only.
- start while busy: ignored.
- ld_valid outside LOAD: ignored, ld_ready = 0.
- Outputs in IDLE and reset values:
  - ca_we_n = 1, ca_halt_n = 0, ca_addr = 0, ca_data_in = 0.
  - ld_ready = 0, sc_valid = 0, sc_last = 0, busy = 0, done = 0, sc_gen = 0.
- Reset mid-operation: next cycle is IDLE with the values above. Array contents are left as they are. No done pulse.

## Timing
- start high in IDLE at edge n -> busy high from cycle n+1. First LOAD or RUN cycle is n+1.
- Load write latency: the array captures the byte on the same edge as the ld handshake.
- Run: gens=G occupies exactly G cycles with ca_halt_n = 1.
- SCAN first beat is valid in the cycle after RUN ends. One block per cycle at full throughput.
- done pulses in the first IDLE cycle after the final scan handshake. busy is low in that same cycle.
- Minimum command length with cfg_load=1, G=0: 1 + 15 + 15 cycles.

## Configuration
- CA_SEQ_SCAN_EACH_EN defined: cfg_scan_each is honoured. Scans are interleaved with single steps (G scans, sc_gen = 1..G), and G=0 gives one scan with sc_gen = 0.
- CA_SEQ_SCAN_EACH_EN undefined: cfg_scan_each is ignored and only the final scan is produced. The per-step RUN/SCAN loop logic is not compiled.

## Structure
- Package ca_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, SCAN);
  - CELLS_PER_BLOCK;
  - the USE_BLOCKS derivation function;
  - GEN_W = 16.
- Single module; no sub-module. The block counter and generation counter are plain registers.

## Test plan
- reset held 3 cycles, then released -> ca_halt_n=0, ca_we_n=1, busy=0, no done pulse.
- start with cfg_load=1, gens=0; bytes 0x00.., block 7 = 0x10 -> scan beat 7 = 0x18, sc_gen=0, sc_last on beat 14, done one cycle later.
- Same load, gens=3 -> exactly 3 cycles with ca_halt_n=1. Scan matches the reference rule-110 model at generation 4.
- sc_ready toggled 0/1 randomly during scan -> sc_data and sc_block held stable while stalled; 15 beats total, no skipped block.
- CA_SEQ_SCAN_EACH_EN defined, gens=2, scan_each=1 -> two 15-beat scans with sc_gen 1 and 2; sc_last only on the second.
- reset asserted mid-LOAD at byte 5 -> IDLE next cycle; ld_ready=0; a subsequent start works normally.
